// File: rtl/wb_traffic_master.sv
// wb_traffic_master: Wishbone classic write/read-back traffic generator.
// Optional ack timeout: define WB_TRAFFIC_TIMEOUT_EN.
module wb_traffic_master #(
  parameter int unsigned BASE_ADDRESS   = 0,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_COUNT     = 16,
  parameter int unsigned ADDR_STRIDE    = 1,
  parameter int unsigned PATTERN_BASE   = 0,
  parameter int unsigned PATTERN_STEP   = 32'h11111111,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_count,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] dat_i
);

  localparam int unsigned IW =
    (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, GAP
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]         idx, idx_n;
  logic                  run_mode, run_mode_n;
  logic                  last_wr, last_wr_n;
  logic                  busy_n, done_n;
  logic [15:0]           err_n;
  logic                  cyc_n, stb_n, we_n;
  logic [ADDR_WIDTH-1:0] adr_n;
  logic [DATA_WIDTH-1:0] dat_n;

  logic [ADDR_WIDTH-1:0] addr_k;
  logic [DATA_WIDTH-1:0] data_k;
  logic                  last;
  logic                  timeout;
  logic                  term;
  logic                  bad;

  assign addr_k = ADDR_WIDTH'(BASE_ADDRESS)
                + ADDR_WIDTH'(idx) * ADDR_WIDTH'(ADDR_STRIDE);
  assign data_k = DATA_WIDTH'(PATTERN_BASE)
                + DATA_WIDTH'(idx) * DATA_WIDTH'(PATTERN_STEP);
  assign last   = (idx == IW'(DATA_COUNT - 1));
  assign term   = ack_i | err_i | timeout;
  assign bad    = err_i | timeout;

`ifdef WB_TRAFFIC_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wcnt;
  logic          in_wait;

  assign in_wait = (state == WR_WAIT) || (state == RD_WAIT);
  assign timeout = in_wait &&
                   (wcnt == TW'(TIMEOUT_CYCLES - 1));

  // cycles spent waiting; cleared whenever not in a wait state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         wcnt <= '0;
    else if (!in_wait) wcnt <= '0;
    else              wcnt <= wcnt + TW'(1);
  end
`else
  // no wait limit: a silent slave stalls the run
  assign timeout = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // state and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      run_mode  <= 1'b0;
      last_wr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      we_o      <= 1'b0;
      adr_o     <= '0;
      dat_o     <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      run_mode  <= run_mode_n;
      last_wr   <= last_wr_n;
      busy      <= busy_n;
      done      <= done_n;
      err_count <= err_n;
      cyc_o     <= cyc_n;
      stb_o     <= stb_n;
      we_o      <= we_n;
      adr_o     <= adr_n;
      dat_o     <= dat_n;
    end
  end

  // sequencing, bus request and checking
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    run_mode_n = run_mode;
    last_wr_n  = last_wr;
    busy_n     = busy;
    done_n     = done;
    err_n      = err_count;
    cyc_n      = cyc_o;
    stb_n      = stb_o;
    we_n       = we_o;
    adr_n      = adr_o;
    dat_n      = dat_o;
    unique case (state)
      IDLE: begin
        if (start) begin
          run_mode_n = mode;
          err_n      = '0;
          done_n     = 1'b0;
          idx_n      = '0;
          busy_n     = 1'b1;
          state_n    = WR_REQ;
        end
      end
      WR_REQ: begin
        cyc_n   = 1'b1;
        stb_n   = 1'b1;
        we_n    = 1'b1;
        adr_n   = addr_k;
        dat_n   = data_k;
        state_n = WR_WAIT;
      end
      RD_REQ: begin
        cyc_n   = 1'b1;
        stb_n   = 1'b1;
        we_n    = 1'b0;
        adr_n   = addr_k;
        state_n = RD_WAIT;
      end
      WR_WAIT: begin
        if (term) begin
          cyc_n     = 1'b0;
          stb_n     = 1'b0;
          we_n      = 1'b0;
          last_wr_n = 1'b1;
          if (bad) err_n = sat_inc(err_count);
          state_n   = GAP;
        end
      end
      RD_WAIT: begin
        if (term) begin
          cyc_n     = 1'b0;
          stb_n     = 1'b0;
          we_n      = 1'b0;
          last_wr_n = 1'b0;
          if (bad || (dat_i != data_k))
            err_n = sat_inc(err_count);
          if (last) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (last_wr) begin
          if (!run_mode) begin
            state_n = RD_REQ;
          end else if (last) begin
            idx_n   = '0;
            state_n = RD_REQ;
          end else begin
            idx_n   = idx + IW'(1);
            state_n = WR_REQ;
          end
        end else begin
          idx_n   = idx + IW'(1);
          state_n = run_mode ? RD_REQ : WR_REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_traffic_master.sv
// tb_wb_traffic_master: directed bench with echo-RAM Wishbone slaves.
// Covers both modes, error injection, wait states and mid-run reset.
module tb_wb_traffic_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, mode;
  logic        busy, done, cyc, stb, we, ack, err;
  logic [15:0] err_count;
  logic [31:0] adr, dat_o, dat_i;

  logic        start2, mode2, busy2, done2, cyc2, stb2, we2;
  logic        ack2, err2;
  logic [15:0] ec2;
  logic [31:0] adr2, dato2, di2;

  assign mode2 = 1'b1;
  assign err2  = 1'b0;

  wb_traffic_master u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .err_count(err_count),
    .cyc_o(cyc), .stb_o(stb), .we_o(we),
    .adr_o(adr), .dat_o(dat_o),
    .ack_i(ack), .err_i(err), .dat_i(dat_i)
  );

  wb_traffic_master #(
    .BASE_ADDRESS(32'h100),
    .ADDR_STRIDE(4)
  ) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2),
    .busy(busy2), .done(done2), .err_count(ec2),
    .cyc_o(cyc2), .stb_o(stb2), .we_o(we2),
    .adr_o(adr2), .dat_o(dato2),
    .ack_i(ack2), .err_i(err2), .dat_i(di2)
  );

  // slave 1: echo RAM, programmable waits, fault injection
  logic [31:0] mem [0:255];
  logic [1:0]  ws = 2'd0;
  logic [1:0]  wc = 2'd0;
  logic [31:0] bad_rd, err_wr;
  initial begin
    ack = 1'b0;
    err = 1'b0;
  end
  always @(posedge clk) begin
    ack <= 1'b0;
    err <= 1'b0;
    if (cyc && stb && !ack && !err) begin
      if (wc == ws) begin
        wc <= 2'd0;
        if (we) mem[adr[7:0]] <= dat_o;
        if (we && adr == err_wr) err <= 1'b1;
        else ack <= 1'b1;
      end else begin
        wc <= wc + 2'd1;
      end
    end
  end
  assign dat_i = mem[adr[7:0]] ^ {31'd0, adr == bad_rd};

  // slave 2: zero-wait echo RAM, word addressed
  logic [31:0] mem2 [0:63];
  initial ack2 = 1'b0;
  always @(posedge clk) begin
    ack2 <= cyc2 && stb2 && !ack2;
    if (cyc2 && stb2 && we2 && !ack2) mem2[adr2[7:2]] <= dato2;
  end
  assign di2 = mem2[adr2[7:2]];

  // transfer logs, cycle counters, stability monitor
  logic [71:0] log1 [0:255];
  logic [71:0] log2 [0:63];
  int n1 = 0, n2 = 0;
  int cyc_hi = 0, busy_cyc = 0, unstable = 0;
  logic        prev_wait = 1'b0;
  logic [64:0] prev_bus = '0;

  always @(posedge clk) begin
    if (cyc && stb && (ack || err)) begin
      log1[n1[7:0]] <= {7'd0, we, adr, dat_o};
      n1 <= n1 + 1;
    end
    if (cyc2 && stb2 && ack2) begin
      log2[n2[5:0]] <= {7'd0, we2, adr2, dato2};
      n2 <= n2 + 1;
    end
    if (cyc) cyc_hi <= cyc_hi + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (cyc && stb && prev_wait && ({we, adr, dat_o} != prev_bus))
      unstable <= unstable + 1;
    prev_wait <= cyc && stb && !ack && !err;
    prev_bus  <= {we, adr, dat_o};
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag,
                       input logic [71:0] got,
                       input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] xfer(input int k, input logic w,
                                       input logic [31:0] a,
                                       input int dk);
    logic [31:0] d;
    d = 32'(dk) * 32'h11111111;
    return {7'd0, w, a, d};
  endfunction

  // mode 0 order: W0,R0,W1,R1,... with dat_o = data(k) throughout
  task automatic chk_mode0(input string tag, input int s);
    for (int t = 0; t < 32; t++) begin
      check($sformatf("%s_%0d", tag, t), log1[(s + t) % 256],
            xfer(t / 2, (t % 2) == 0, 32'(t / 2), t / 2));
    end
  endtask

  task automatic run1(input logic m, input int mid, output int s,
                      output int nd);
    s = n1;
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (i == mid) begin
        start = 1'b1;
        mode  = ~m;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    mode  = m;
    nd    = n1 - s;
    check("run_done", 72'(done), 72'd1);
  endtask

  int s, nd, c0, b0, u0;
  logic hit;

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    mode   = 1'b0;
    start2 = 1'b0;
    bad_rd = '1;
    err_wr = '1;
    repeat (2) @(negedge clk);
    check("rst_ctl", 72'({busy, done, err_count, cyc, stb, we}), 72'd0);
    check("rst_bus", 72'({adr, dat_o}), 72'd0);
    rst = 1'b1;
    @(negedge clk);

    // mode 1, base 0x100, stride 4
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 3000 && !done2; i++) @(negedge clk);
    check("m1_done", 72'({done2, busy2}), 72'b10);
    check("m1_cnt", 72'(n2), 72'd32);
    check("m1_err", 72'(ec2), 72'd0);
    for (int t = 0; t < 32; t++) begin
      check($sformatf("m1_%0d", t), log2[t],
            xfer(t % 16, t < 16, 32'h100 + 32'((t % 16) * 4),
                 t < 16 ? t : 15));
    end

    // mode 0, zero-wait, duty cycle
    c0 = cyc_hi;
    b0 = busy_cyc;
    run1(1'b0, -1, s, nd);
    check("m0_cnt", 72'(nd), 72'd32);
    check("m0_stat", 72'({busy, err_count}), 72'd0);
    check("m0_cyc", 72'(cyc_hi - c0), 72'd64);
    check("m0_busy", 72'(busy_cyc - b0), 72'd127);
    chk_mode0("m0", s);

    // read corruption on word 5, err_i on write of word 9
    bad_rd = 32'd5;
    err_wr = 32'd9;
    run1(1'b0, -1, s, nd);
    check("inj_err", 72'(err_count), 72'd2);
    check("inj_cnt", 72'(nd), 72'd32);
    bad_rd = '1;
    err_wr = '1;

    // three wait states, stray start and mode flip mid-run
    ws = 2'd3;
    u0 = unstable;
    run1(1'b0, 40, s, nd);
    check("ws_cnt", 72'(nd), 72'd32);
    check("ws_err", 72'(err_count), 72'd0);
    check("ws_stable", 72'(unstable - u0), 72'd0);
    chk_mode0("ws", s);
    repeat (3) @(negedge clk);
    check("ws_norerun", 72'({busy, done}), 72'b01);
    ws = 2'd0;

    // reset during RD_WAIT of word 7
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    hit   = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = cyc && !we && (adr == 32'd7);
    end
    check("rst_hit", 72'(hit), 72'd1);
    #1 rst = 1'b0;
    #1;
    check("arst_ctl", 72'({busy, done, err_count, cyc, stb, we}), 72'd0);
    check("arst_bus", 72'({adr, dat_o}), 72'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run1(1'b0, -1, s, nd);
    check("post_cnt", 72'(nd), 72'd32);
    check("post_err", 72'(err_count), 72'd0);
    check("post_w0", log1[s % 256], xfer(0, 1'b1, 32'd0, 0));
    chk_mode0("post", s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
